// File: rtl/cache_pkg.sv
// Shared types for the cache miss-handling logic: FSM state encoding and way indexing.
package cache_pkg;

    localparam int NUM_WAYS = 4;

    typedef logic [1:0] way_t;

    typedef enum logic [2:0] {
        IDLE,
        VICTIM,
        WB,
        FETCH,
        FILL,
        DONE
    } miss_state_e;

endpackage

// File: rtl/victim_select.sv
// Replacement choice for one set: the lowest-index invalid way wins, otherwise the PLRU way.
module victim_select
    import cache_pkg::*;
(
    input  logic [NUM_WAYS-1:0] way_valid,
    input  logic [1:0]          plru_dout,
    output logic [1:0]          victim
);

    // Scan from the top so the lowest invalid index is the last one written.
    always_comb begin
        victim = plru_dout;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!way_valid[i]) begin
                victim = way_t'(i);
            end
        end
    end

endmodule

// File: rtl/cache_miss_ctrl.sv
// Miss controller: selects a victim, writes it back when dirty, fetches the missing line,
// strobes the fill and reports completion. Also forwards hits to the PLRU update port.
module cache_miss_ctrl
    import cache_pkg::*;
#(
    parameter int TAG_W = 23,
    parameter int IDX_W = 4,
    parameter int OFF_W = 5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           hit_valid,
    input  logic [1:0]                     hit_way,
    input  logic                           miss_req,
    input  logic [TAG_W-1:0]               req_tag,
    input  logic [IDX_W-1:0]               req_idx,
    input  logic [NUM_WAYS-1:0]            way_valid,
    input  logic [NUM_WAYS-1:0]            way_dirty,
    input  logic [NUM_WAYS*TAG_W-1:0]      way_tag,
    input  logic [1:0]                     plru_dout,
    output logic                           plru_csb,
    output logic                           plru_web,
    output logic [1:0]                     plru_din,
    output logic                           pmem_read,
    output logic                           pmem_write,
    input  logic                           pmem_resp,
    output logic [TAG_W+IDX_W+OFF_W-1:0]   pmem_address,
    output logic [1:0]                     wb_way,
    output logic                           fill_we,
    output logic [1:0]                     fill_way,
    output logic                           miss_done
);

    miss_state_e      state;
    logic [1:0]       victim_q;
    logic [1:0]       victim_c;
    logic             victim_dirty;
    logic [TAG_W-1:0] victim_tag;
    logic             hit_upd;

    victim_select u_victim_select (
        .way_valid (way_valid),
        .plru_dout (plru_dout),
        .victim    (victim_c)
    );

    assign victim_dirty = way_valid[victim_c] & way_dirty[victim_c];
    assign victim_tag   = way_tag[int'(victim_c) * TAG_W +: TAG_W];

    // Memory handshake: pmem_read/pmem_write is a level request that rises on entry to
    // FETCH/WB and stays high, with pmem_address frozen, through the cycle pmem_resp is
    // seen; only then does it drop. The two requests are never raised together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            victim_q     <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            wb_way       <= '0;
            fill_we      <= 1'b0;
            fill_way     <= '0;
            miss_done    <= 1'b0;
        end else begin
            fill_we   <= 1'b0;
            miss_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (miss_req) begin
                        state <= VICTIM;
                    end
                end
                VICTIM: begin
                    victim_q <= victim_c;
                    if (victim_dirty) begin
                        state        <= WB;
                        pmem_write   <= 1'b1;
                        pmem_address <= {victim_tag, req_idx, {OFF_W{1'b0}}};
                        wb_way       <= victim_c;
                    end else begin
                        state        <= FETCH;
                        pmem_read    <= 1'b1;
                        pmem_address <= {req_tag, req_idx, {OFF_W{1'b0}}};
                    end
                end
                WB: begin
                    if (pmem_resp) begin
                        state        <= FETCH;
                        pmem_write   <= 1'b0;
                        wb_way       <= '0;
                        pmem_read    <= 1'b1;
                        pmem_address <= {req_tag, req_idx, {OFF_W{1'b0}}};
                    end
                end
                FETCH: begin
                    if (pmem_resp) begin
                        state        <= FILL;
                        pmem_read    <= 1'b0;
                        pmem_address <= '0;
                        fill_we      <= 1'b1;
                        fill_way     <= victim_q;
                    end
                end
                FILL: begin
                    state     <= DONE;
                    fill_way  <= '0;
                    miss_done <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state        <= IDLE;
                    pmem_read    <= 1'b0;
                    pmem_write   <= 1'b0;
                    pmem_address <= '0;
                    wb_way       <= '0;
                    fill_way     <= '0;
                end
            endcase
        end
    end

    // A miss request arriving in IDLE takes priority over a hit in the same cycle.
    assign hit_upd = (state == IDLE) & hit_valid & ~miss_req;

    always_comb begin
        plru_csb = 1'b1;
        plru_web = 1'b1;
        plru_din = '0;
        if (fill_we) begin
            plru_csb = 1'b0;
            plru_web = 1'b0;
            plru_din = fill_way;
        end else if (hit_upd) begin
            plru_csb = 1'b0;
            plru_web = 1'b0;
            plru_din = hit_way;
        end
    end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed bench for cache_miss_ctrl: drivers push expected events, a negedge monitor
// pops and compares each PLRU update, memory completion, fill strobe and done pulse.
module tb_cache_miss_ctrl;

    localparam int TAG_W  = 23;
    localparam int IDX_W  = 4;
    localparam int OFF_W  = 5;
    localparam int ADDR_W = TAG_W + IDX_W + OFF_W;
    localparam int EV_W   = 3 + 2 + ADDR_W;
    localparam int OUT_W  = 4 + 2 + 6 + ADDR_W;

    localparam logic [2:0] K_PLRU = 3'd1;
    localparam logic [2:0] K_WR   = 3'd2;
    localparam logic [2:0] K_RD   = 3'd3;
    localparam logic [2:0] K_FILL = 3'd4;
    localparam logic [2:0] K_DONE = 3'd5;

    logic                 clk;
    logic                 rst_n;
    logic                 hit_valid;
    logic [1:0]           hit_way;
    logic                 miss_req;
    logic [TAG_W-1:0]     req_tag;
    logic [IDX_W-1:0]     req_idx;
    logic [3:0]           way_valid;
    logic [3:0]           way_dirty;
    logic [4*TAG_W-1:0]   way_tag;
    logic [1:0]           plru_dout;
    logic                 plru_csb;
    logic                 plru_web;
    logic [1:0]           plru_din;
    logic                 pmem_read;
    logic                 pmem_write;
    logic                 pmem_resp;
    logic [ADDR_W-1:0]    pmem_address;
    logic [1:0]           wb_way;
    logic                 fill_we;
    logic [1:0]           fill_way;
    logic                 miss_done;

    logic [EV_W-1:0] exp_q[$];
    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int miss_start = 0;

    logic [OUT_W-1:0] idle_outs;

    cache_miss_ctrl #(
        .TAG_W (TAG_W),
        .IDX_W (IDX_W),
        .OFF_W (OFF_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hit_valid    (hit_valid),
        .hit_way      (hit_way),
        .miss_req     (miss_req),
        .req_tag      (req_tag),
        .req_idx      (req_idx),
        .way_valid    (way_valid),
        .way_dirty    (way_dirty),
        .way_tag      (way_tag),
        .plru_dout    (plru_dout),
        .plru_csb     (plru_csb),
        .plru_web     (plru_web),
        .plru_din     (plru_din),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_resp    (pmem_resp),
        .pmem_address (pmem_address),
        .wb_way       (wb_way),
        .fill_we      (fill_we),
        .fill_way     (fill_way),
        .miss_done    (miss_done)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- helpers ----------------
    function automatic logic [EV_W-1:0] ev(input logic [2:0] k, input logic [1:0] w,
                                           input logic [ADDR_W-1:0] a);
        return {k, w, a};
    endfunction

    function automatic logic [4*TAG_W-1:0] pack_tags(input logic [TAG_W-1:0] t0, t1, t2, t3);
        return {t3, t2, t1, t0};
    endfunction

    function automatic logic [OUT_W-1:0] outs_now();
        return {pmem_read, pmem_write, fill_we, miss_done, plru_csb, plru_web,
                plru_din, wb_way, fill_way, pmem_address};
    endfunction

    task automatic check_vec(input string name, input logic [OUT_W-1:0] got,
                             input logic [OUT_W-1:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic see(input string name, input logic [EV_W-1:0] got);
        logic [EV_W-1:0] exp;
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL %s: got event=%h expected no event (t=%0t)", name, got, $time);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                mismatched++;
                $display("FAIL %s: got event=%h expected=%h (t=%0t)", name, got, exp, $time);
            end
        end
    endtask

    logic              prev_req  = 1'b0;
    logic              prev_wr   = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            compared++;
            if (pmem_read && pmem_write) begin
                mismatched++;
                $display("FAIL pmem_excl: read=%b write=%b expected not both 1", pmem_read, pmem_write);
            end
            compared++;
            if (plru_csb ? (plru_web !== 1'b1 || plru_din !== 2'd0) : (plru_web !== 1'b0)) begin
                mismatched++;
                $display("FAIL plru_port: csb=%b web=%b din=%0d expected web==csb, din=0 when idle",
                         plru_csb, plru_web, plru_din);
            end
            if (prev_req && (pmem_read || pmem_write) && (pmem_write == prev_wr)) begin
                compared++;
                if (pmem_address !== prev_addr) begin
                    mismatched++;
                    $display("FAIL addr_hold: got=%h expected=%h", pmem_address, prev_addr);
                end
            end
            if (!plru_csb)              see("plru_upd", ev(K_PLRU, plru_din, '0));
            if (pmem_resp && pmem_write) see("wb_xfer", ev(K_WR, wb_way, pmem_address));
            if (pmem_resp && pmem_read)  see("rd_xfer", ev(K_RD, 2'd0, pmem_address));
            if (fill_we)                 see("fill", ev(K_FILL, fill_way, '0));
            if (miss_done)               see("done_lat", ev(K_DONE, 2'd0, ADDR_W'(cyc - miss_start)));
            prev_req  = (pmem_read || pmem_write) && !pmem_resp;
            prev_wr   = pmem_write;
            prev_addr = pmem_address;
        end else begin
            prev_req = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_hit(input logic [1:0] w);
        exp_q.push_back(ev(K_PLRU, w, '0));
        hit_valid = 1'b1;
        hit_way   = w;
        step();
        hit_valid = 1'b0;
    endtask

    task automatic run_miss(input logic [TAG_W-1:0] tag, input logic [IDX_W-1:0] idx,
                            input logic [3:0] valid, input logic [3:0] dirty,
                            input logic [4*TAG_W-1:0] tags, input logic [1:0] plru,
                            input logic [1:0] exp_victim, input bit exp_wb,
                            input logic [TAG_W-1:0] exp_wb_tag,
                            input int wb_lat, input int rd_lat,
                            input bit hit_at_start, input bit hit_in_fetch);
        int cnt;
        bit done;
        if (exp_wb) exp_q.push_back(ev(K_WR, exp_victim, {exp_wb_tag, idx, {OFF_W{1'b0}}}));
        exp_q.push_back(ev(K_RD, 2'd0, {tag, idx, {OFF_W{1'b0}}}));
        exp_q.push_back(ev(K_PLRU, exp_victim, '0));
        exp_q.push_back(ev(K_FILL, exp_victim, '0));
        exp_q.push_back(ev(K_DONE, 2'd0, ADDR_W'(3 + (exp_wb ? wb_lat : 0) + rd_lat)));
        req_tag   = tag;
        req_idx   = idx;
        way_valid = valid;
        way_dirty = dirty;
        way_tag   = tags;
        plru_dout = plru;
        miss_req  = 1'b1;
        hit_valid = hit_at_start;
        hit_way   = 2'd1;
        miss_start = cyc;
        cnt  = 0;
        done = 1'b0;
        for (int c = 0; c < 200; c++) begin
            step();
            pmem_resp = 1'b0;
            hit_valid = 1'b0;
            if (miss_done) begin
                done = 1'b1;
                break;
            end
            if (pmem_write || pmem_read) begin
                cnt++;
                if (pmem_read && hit_in_fetch) begin
                    hit_valid = 1'b1;
                    hit_way   = 2'd3;
                end
                if (cnt == (pmem_write ? wb_lat : rd_lat)) begin
                    pmem_resp = 1'b1;
                    cnt = 0;
                end
            end
        end
        miss_req  = 1'b0;
        pmem_resp = 1'b0;
        hit_valid = 1'b0;
        if (!done) begin
            compared++;
            mismatched++;
            $display("FAIL miss_timeout: got no miss_done in 200 cycles expected one (tag=%h)", tag);
        end
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit seen;
        idle_outs = {4'b0000, 2'b11, 6'b000000, {ADDR_W{1'b0}}};
        rst_n     = 1'b0;
        hit_valid = 1'b0;
        hit_way   = 2'd0;
        miss_req  = 1'b0;
        req_tag   = '0;
        req_idx   = '0;
        way_valid = '0;
        way_dirty = '0;
        way_tag   = '0;
        plru_dout = '0;
        pmem_resp = 1'b0;

        #2;
        check_vec("reset_outs", outs_now(), idle_outs);
        step();
        step();
        check_vec("reset_hold", outs_now(), idle_outs);
        rst_n = 1'b1;
        step();
        check_vec("post_reset_idle", outs_now(), idle_outs);

        // Hits in IDLE update the tree in the same cycle.
        do_hit(2'd2);
        do_hit(2'd0);
        do_hit(2'd3);
        step();

        // Clean miss into the lowest invalid way; invalid-way dirty bit must not cause writeback.
        run_miss(23'h05A5A5, 4'h7, 4'b1011, 4'b0100,
                 pack_tags(23'h000111, 23'h000222, 23'h000333, 23'h000444), 2'd0,
                 2'd2, 1'b0, '0, 0, 3, 1'b0, 1'b0);

        // Dirty miss with all ways valid: PLRU victim 3 written back first.
        run_miss(23'h7ABCDE, 4'h3, 4'hF, 4'b1000,
                 pack_tags(23'h000AAA, 23'h000BBB, 23'h000CCC, 23'h001234), 2'd3,
                 2'd3, 1'b1, 23'h001234, 4, 2, 1'b0, 1'b0);

        // All valid, PLRU victim clean; hit coincident with miss_req is dropped.
        run_miss(23'h000F0F, 4'hE, 4'hF, 4'b1000,
                 pack_tags(23'h000001, 23'h000002, 23'h000003, 23'h000004), 2'd1,
                 2'd1, 1'b0, '0, 0, 1, 1'b1, 1'b0);

        // Empty set picks way 0 regardless of PLRU; a hit during FETCH is ignored.
        run_miss(23'h400001, 4'h0, 4'b0000, 4'b1111,
                 pack_tags(23'h7FFFFF, 23'h7FFFFF, 23'h7FFFFF, 23'h7FFFFF), 2'd2,
                 2'd0, 1'b0, '0, 0, 3, 1'b0, 1'b1);

        // Dirty victim at way 0 with single-cycle memory responses.
        run_miss(23'h123456, 4'hF, 4'hF, 4'b0001,
                 pack_tags(23'h2AAAAA, 23'h000BBB, 23'h000CCC, 23'h000DDD), 2'd0,
                 2'd0, 1'b1, 23'h2AAAAA, 1, 1, 1'b0, 1'b0);

        // Stray response in IDLE changes nothing.
        pmem_resp = 1'b1;
        #1;
        check_vec("stray_resp_same", outs_now(), idle_outs);
        step();
        pmem_resp = 1'b0;
        check_vec("stray_resp_next", outs_now(), idle_outs);
        step();
        do_hit(2'd1);

        // Reset asserted during writeback aborts the miss immediately.
        req_tag   = 23'h0C0FFE;
        req_idx   = 4'h5;
        way_valid = 4'hF;
        way_dirty = 4'b0001;
        way_tag   = pack_tags(23'h000ABC, 23'h1, 23'h2, 23'h3);
        plru_dout = 2'd0;
        miss_req  = 1'b1;
        miss_start = cyc;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (pmem_write) begin
                seen = 1'b1;
                break;
            end
        end
        compared++;
        if (!seen) begin
            mismatched++;
            $display("FAIL rst_wb_entry: got no pmem_write in 10 cycles expected WB");
        end
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_vec("rst_mid_wb", outs_now(), idle_outs);
        miss_req = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        repeat (5) step();
        check_vec("rst_recover_idle", outs_now(), idle_outs);
        do_hit(2'd2);
        repeat (3) step();

        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL queue_drain: got %0d pending events expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
